grf_write_arbiter: RTL and testbench
====================================

// Module: grf_write_arbiter
// PURPOSE
//  Sole writer of the GRF write port. Merges in-order WB-stage writes with out-of-order
//  results from long-latency units (MDU, CP0 reads) delivered on a valid/ready channel.
//  Late results are queued in a small FIFO and drained into free WB slots.
//  Exports a per-register pending mask so the hazard unit stalls readers of queued results.
// PARAMETERS
//  DEPTH     4   late-result FIFO entries (power of 2, >=2)
//  MAX_WAIT  8   consecutive lost-arbitration cycles before wb_stall is raised
// PORTS
//  clk        in   1   clock
//  reset      in   1   synchronous, active-high
//  wb_we      in   1   WB-stage write request; never back-pressured
//  wb_addr    in   5   WB destination register
//  wb_data    in   32  WB write data
//  wb_pc      in   32  PC of WB instruction (trace)
//  lu_valid   in   1   late-unit result valid
//  lu_ready   out  1   FIFO can accept (= !full && !reset)
//  lu_addr    in   5   late-unit destination register
//  lu_data    in   32  late-unit result
//  lu_pc      in   32  PC of originating instruction (trace)
//  grf_we     out  1   to GRF RegWrite
//  grf_addr   out  5   to GRF A3
//  grf_data   out  32  to GRF WriteData
//  grf_pc     out  32  to GRF PC
//  pending    out  32  bit r = 1 while a stored FIFO entry targets $r; bit 0 always 0
//  wb_stall   out  1   request: pipeline must put a bubble (wb_we=0) in WB next cycle
// BEHAVIOUR
//  Reset (reset, active-high): FIFO empty, rd/wr pointers 0, wait counter 0, wb_stall 0,
//   pending 0. lu_ready=0 and grf_we=0 while reset is high. Reset mid-drain drops queued entries.
//  Accept: lu_valid && lu_ready pushes {addr,data,pc} at posedge. An entry pushed at edge t
//   can issue at the earliest in the cycle after t.
//   lu_addr==0 is handshaken but not stored (no entry, no pending bit).
//  Issue (combinational, 0 latency), priority:
//   1) wb_we && wb_addr!=0 -> grf_* = wb_*, FIFO not popped.
//   2) else FIFO non-empty -> grf_* = head, grf_we=1, pop at edge.
//   3) else grf_we=0; grf_addr/data/pc = 0.
//   wb_we with wb_addr==0 counts as a free slot (FIFO may drain).
//  Simultaneous push+pop when full: lu_ready stays 0 that cycle (ready depends on state only).
//  Simultaneous push+pop otherwise: both take effect; count unchanged.
//  Pointers: log2(DEPTH)+1 bits, wrap modulo 2*DEPTH; full = MSBs differ, low bits equal.
//  pending: OR over stored valid entries of (1<<addr); updated at the same edge as push/pop.
//   Not set for the in-flight lu_valid beat (hazard unit decodes lu_* itself).
//  Starvation: wait counter increments each cycle FIFO non-empty and WB wins; clears on any
//   pop or when empty. When counter==MAX_WAIT-1 and WB wins again, wb_stall=1 for exactly
//   one cycle (registered). If wb_we is still asserted during wb_stall, WB still wins
//   (no data lost) and counter saturates, holding wb_stall high until a pop occurs.
//  Ordering: block never reorders entries of one source. WAW/RAW between sources is
//   prevented by the hazard unit stalling on pending[r]; a WB write to r while pending[r]=1
//   is a protocol violation (simulation assertion, error message with $time and wb_pc).
// STRUCTURE
//  Shared package/header: REG_AW=5, DATA_W=32, GRF_ZERO=5'd0, entry struct
//   {addr[4:0], data[31:0], pc[31:0]} (69 bits).
//  One sub-module: late_fifo (synchronous DEPTH-entry FIFO, push/pop/full/empty,
//   exposes all entries' addr+valid for pending decode). Arbiter, counter, mask at top.
// TESTING
//  1. Reset then wb_we=1,addr=8,data=0x1234 -> same cycle grf_we=1,addr=8,data=0x1234; pending=0.
//  2. lu push addr=3,data=0xAA at t, wb idle -> pending[3]=1 after t; grf write $3=0xAA at t+1;
//     pending[3]=0 after t+1.
//  3. Push addr 4,5,6,7 with wb busy -> lu_ready=0 after 4th; drains 4,5,6,7 in order once wb idle.
//  4. FIFO holds 1 entry, wb_we=1 for 8 cycles -> wb_stall=1 on 9th cycle; bubble -> pop, wb_stall=0.
//  5. lu push addr=0 -> handshake completes, no pending bit, no grf_we; wb addr=0 -> grf_we=0.
//  6. Full FIFO, assert reset one cycle -> FIFO empty, pending=0, no grf_we from stale entries.

Source files
------------

// File: rtl/grf_write_arbiter_pkg.sv
// Shared widths, constants and the late-result entry payload for the GRF write arbiter.
package grf_write_arbiter_pkg;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned DATA_W = 32;

    localparam logic [REG_AW-1:0] GRF_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] pc;
    } grf_entry_t;

endpackage

// File: rtl/grf_write_arbiter_late_fifo.sv
// Synchronous FIFO holding late-unit results; exposes every slot's addr/valid
// so the top can build the pending-register mask.
module grf_write_arbiter_late_fifo
    import grf_write_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              push_i,
    input  grf_entry_t                        push_entry_i,
    input  logic                              pop_i,
    output grf_entry_t                        head_o,
    output logic                              full_o,
    output logic                              empty_o,
    output logic [DEPTH-1:0]                  valid_o,
    output logic [DEPTH-1:0][REG_AW-1:0]      addr_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    grf_entry_t [DEPTH-1:0] mem_q;
    logic [PW-1:0]          wr_q, wr_d;
    logic [PW-1:0]          rd_q, rd_d;
    logic [DEPTH-1:0]       valid_q, valid_d;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[PW-1] != rd_q[PW-1]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign head_o  = mem_q[rd_q[AW-1:0]];
    assign valid_o = valid_q;

    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            addr_o[i] = mem_q[i].addr;
        end
    end

    // Pop clears the head slot, push marks the tail slot; they never alias since push implies !full.
    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        valid_d = valid_q;
        if (pop_i) begin
            valid_d[rd_q[AW-1:0]] = 1'b0;
            rd_d                  = rd_q + PW'(1);
        end
        if (push_i) begin
            valid_d[wr_q[AW-1:0]] = 1'b1;
            wr_d                  = wr_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            valid_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_q[AW-1:0]] <= push_entry_i;
        end
    end

endmodule

// File: rtl/grf_write_arbiter.sv
// Sole GRF write-port owner: WB writes win, queued late-unit results fill free slots,
// with a starvation counter that asks the pipeline for a bubble.
module grf_write_arbiter
    import grf_write_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [DATA_W-1:0] wb_pc,
    input  logic              lu_valid,
    output logic              lu_ready,
    input  logic [REG_AW-1:0] lu_addr,
    input  logic [DATA_W-1:0] lu_data,
    input  logic [DATA_W-1:0] lu_pc,
    output logic              grf_we,
    output logic [REG_AW-1:0] grf_addr,
    output logic [DATA_W-1:0] grf_data,
    output logic [DATA_W-1:0] grf_pc,
    output logic [31:0]       pending,
    output logic              wb_stall
);

    localparam int unsigned WW = $clog2(MAX_WAIT + 1);

    grf_entry_t                   head;
    grf_entry_t                   push_entry;
    logic                         fifo_full, fifo_empty;
    logic [DEPTH-1:0]             ent_valid;
    logic [DEPTH-1:0][REG_AW-1:0] ent_addr;
    logic                         wb_win_c, push_c, pop_c;
    logic [WW-1:0]                wait_q, wait_d;
    logic                         stall_q, stall_d;

    assign lu_ready   = !fifo_full && !reset;
    assign wb_win_c   = wb_we && (wb_addr != GRF_ZERO);
    assign pop_c      = !reset && !wb_win_c && !fifo_empty;
    assign push_c     = lu_valid && lu_ready && (lu_addr != GRF_ZERO);
    assign push_entry = '{addr: lu_addr, data: lu_data, pc: lu_pc};

    grf_write_arbiter_late_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_i       (push_c),
        .push_entry_i (push_entry),
        .pop_i        (pop_c),
        .head_o       (head),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .valid_o      (ent_valid),
        .addr_o       (ent_addr)
    );

    always_comb begin
        grf_we   = 1'b0;
        grf_addr = '0;
        grf_data = '0;
        grf_pc   = '0;
        if (!reset) begin
            if (wb_win_c) begin
                grf_we   = 1'b1;
                grf_addr = wb_addr;
                grf_data = wb_data;
                grf_pc   = wb_pc;
            end else if (!fifo_empty) begin
                grf_we   = 1'b1;
                grf_addr = head.addr;
                grf_data = head.data;
                grf_pc   = head.pc;
            end
        end
    end

    // Register 0 is never stored, so bit 0 stays clear.
    always_comb begin
        pending = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (ent_valid[i]) begin
                pending[ent_addr[i]] = 1'b1;
            end
        end
    end

    // Non-empty without a pop means WB won; saturate at MAX_WAIT-1 and keep stalling.
    always_comb begin
        wait_d  = wait_q;
        stall_d = 1'b0;
        if (fifo_empty || pop_c) begin
            wait_d = '0;
        end else if (wait_q == WW'(MAX_WAIT - 1)) begin
            stall_d = 1'b1;
        end else begin
            wait_d = wait_q + WW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_q  <= '0;
            stall_q <= 1'b0;
        end else begin
            wait_q  <= wait_d;
            stall_q <= stall_d;
        end
    end

    assign wb_stall = stall_q;

    a_no_wb_to_pending: assert property (@(posedge clk) disable iff (reset)
        !(wb_win_c && pending[wb_addr]))
        else $error("grf_write_arbiter: WB write to pending register at time %0t, wb_pc=%h", $time, wb_pc);

endmodule

// File: tb/tb_grf_write_arbiter.sv
// Directed scenarios plus randomized traffic checked cycle-by-cycle against a queue-based model.
module tb_grf_write_arbiter;
    import grf_write_arbiter_pkg::*;

    localparam int unsigned DEPTH    = 4;
    localparam int unsigned MAX_WAIT = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_we, lu_valid, lu_ready;
    logic [4:0]  wb_addr, lu_addr, grf_addr;
    logic [31:0] wb_data, wb_pc, lu_data, lu_pc, grf_data, grf_pc, pending;
    logic        grf_we, wb_stall;

    int errors = 0;
    int checks = 0;

    grf_entry_t q[$];
    int         lost = 0;
    bit         stall_m = 1'b0;

    always #5 clk = ~clk;

    grf_write_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .wb_pc(wb_pc),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_addr(lu_addr),
        .lu_data(lu_data), .lu_pc(lu_pc),
        .grf_we(grf_we), .grf_addr(grf_addr), .grf_data(grf_data), .grf_pc(grf_pc),
        .pending(pending), .wb_stall(wb_stall)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_pending();
        logic [31:0] p = '0;
        foreach (q[i]) p[q[i].addr] = 1'b1;
        return p;
    endfunction

    // One clock cycle: drive, check combinational outputs against the model, then advance the model.
    task automatic step(input bit rst, input bit wwe, input logic [4:0] wa, input logic [31:0] wd,
                        input bit lv, input logic [4:0] la, input logic [31:0] ld);
        bit          exp_ready, wb_win, popped, was_empty;
        logic        exp_we;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data, exp_pc;
        grf_entry_t  e;
        @(negedge clk);
        reset = rst; wb_we = wwe; wb_addr = wa; wb_data = wd; wb_pc = wd ^ 32'hC000_0000;
        lu_valid = lv; lu_addr = la; lu_data = ld; lu_pc = ld + 32'd4;
        #1;
        exp_ready = !rst && (q.size() < DEPTH);
        wb_win    = wwe && (wa != 5'd0);
        was_empty = (q.size() == 0);
        exp_we = 1'b0; exp_addr = '0; exp_data = '0; exp_pc = '0;
        if (!rst && wb_win) begin
            exp_we = 1'b1; exp_addr = wa; exp_data = wd; exp_pc = wd ^ 32'hC000_0000;
        end else if (!rst && !was_empty) begin
            exp_we = 1'b1; exp_addr = q[0].addr; exp_data = q[0].data; exp_pc = q[0].pc;
        end
        check_eq("lu_ready", 32'(lu_ready), 32'(exp_ready));
        check_eq("grf_we",   32'(grf_we),   32'(exp_we));
        check_eq("grf_addr", 32'(grf_addr), 32'(exp_addr));
        check_eq("grf_data", grf_data, exp_data);
        check_eq("grf_pc",   grf_pc,   exp_pc);
        check_eq("pending",  pending,  model_pending());
        check_eq("wb_stall", 32'(wb_stall), 32'(stall_m));
        @(posedge clk);
        if (rst) begin
            q.delete(); lost = 0; stall_m = 1'b0;
        end else begin
            popped = !wb_win && !was_empty;
            if (popped) void'(q.pop_front());
            if (lv && exp_ready && la != 5'd0) begin
                e.addr = la; e.data = ld; e.pc = ld + 32'd4;
                q.push_back(e);
            end
            if (was_empty || popped) begin
                lost = 0; stall_m = 1'b0;
            end else if (lost == int'(MAX_WAIT) - 1) begin
                stall_m = 1'b1;
            end else begin
                lost++; stall_m = 1'b0;
            end
        end
    endtask

    initial begin
        logic [31:0] pm;
        bit          rst, wwe, lv;
        logic [4:0]  wa, la;
        int          busy;

        reset = 1'b1; wb_we = 0; wb_addr = '0; wb_data = '0; wb_pc = '0;
        lu_valid = 0; lu_addr = '0; lu_data = '0; lu_pc = '0;
        repeat (2) @(posedge clk);

        // Reset state, then a plain WB write.
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 8, 32'h1234, 0, 0, 0);

        // Single late result drains into the next idle slot.
        step(0, 0, 0, 0, 1, 3, 32'hAA);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // Fill while WB busy, then drain in order.
        for (int i = 0; i < 5; i++) step(0, 1, 8, 32'h100 + 32'(i), 1, 5'(4 + i), 32'h40 + 32'(i));
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 0);

        // Starvation: one entry, WB busy for eight cycles, then a bubble.
        step(0, 1, 9, 32'h900, 1, 10, 32'hA0);
        for (int i = 0; i < 8; i++) step(0, 1, 9, 32'h901 + 32'(i), 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // Register-0 traffic is handshaken / ignored.
        step(0, 0, 0, 0, 1, 0, 32'hDEAD);
        step(0, 1, 0, 32'hBEEF, 0, 0, 0);

        // Reset with a full FIFO discards everything.
        for (int i = 0; i < 4; i++) step(0, 1, 8, 32'h200 + 32'(i), 1, 5'(12 + i), 32'h70 + 32'(i));
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0);

        // Randomized traffic with alternating WB load.
        for (int n = 0; n < 800; n++) begin
            busy = ((n / 100) % 2 == 1) ? 90 : 40;
            rst  = ($urandom_range(0, 79) == 0);
            wwe  = ($urandom_range(0, 99) < busy);
            wa   = 5'($urandom_range(0, 31));
            pm   = model_pending();
            if (pm[wa]) wwe = 1'b0;
            lv   = ($urandom_range(0, 1) == 1);
            la   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            step(rst, wwe, wa, $urandom, lv, la, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
